score_tracker: RTL and testbench
================================

// Module: score_tracker
// PURPOSE
//  Tracks the current and high score of a snake-style game. Counts one point per
//  good collision (apple eaten) and ends the game on a bad collision or on
//  reaching the maximum score. Sits between the collision detector and the
//  score display.
// PARAMETERS
//  MAX_SCORE  7'd99  score at which the game is won; must be >= 1 and <= 127
// PORTS
//  clk             input   1  system clock; all logic on rising edge
//  nRst            input   1  reset; synchronous, active-high (1 = reset)
//  goodColl        input   1  good-collision level; one point per 0->1 transition
//  badColl         input   1  bad-collision level; ends the game while high
//  currScore       output  7  current game score, registered
//  highScore       output  7  highest score since reset, registered
//  isGameComplete  output  1  game-over flag (loss or win), registered, sticky
// BEHAVIOUR
//  - Reset: nRst=1 at a clk edge -> currScore=0, highScore=0, isGameComplete=0,
//    goodColl history register=0. Reset has priority over every other event,
//    including mid-game.
//  - Edge detect: goodColl_prev register samples goodColl every cycle.
//    goodEdge = goodColl & ~goodColl_prev. Holding goodColl high scores once only.
//  - Increment: at the edge where goodEdge=1, badColl=0 and isGameComplete=0,
//    currScore <= currScore+1. Latency is 1 cycle from goodColl rise to the
//    output update.
//  - highScore: next = max(highScore, currScore_next), updated on the same edge
//    as currScore. It never decreases; only nRst clears it.
//  - Loss: badColl=1 and isGameComplete=0 -> isGameComplete<=1 on that edge;
//    currScore holds.
//  - Win: an increment that makes currScore_next==MAX_SCORE also sets
//    isGameComplete<=1 on the same edge. currScore never exceeds MAX_SCORE and
//    never wraps.
//  - Simultaneous goodEdge and badColl: badColl wins; no increment and the game
//    ends.
//  - While isGameComplete=1: currScore, highScore and isGameComplete hold;
//    goodColl and badColl are ignored (except as noted under CONFIGURATION).
//  - Widths: all score arithmetic is 7-bit unsigned; compare before add, so
//    there is no overflow.
// CONFIGURATION
//  SCORE_TRACKER_RESTART_EN
//  - Defined: while isGameComplete=1, a goodEdge with badColl=0 starts a new
//    game. On that edge currScore<=0 and isGameComplete<=0; highScore is
//    retained. The restart edge does not score.
//  - Undefined: isGameComplete stays set until nRst.
// TESTING
//  - Reset: nRst=1 for 2 cycles -> currScore=0, highScore=0, isGameComplete=0;
//    values hold through another cycle with nRst=1.
//  - Single apple: goodColl=1 held for 3 cycles after reset -> currScore=1 and
//    highScore=1 one cycle after the rise; both still 1 while goodColl stays high.
//  - Five pulses of goodColl (1 cycle high, 1 low) -> currScore=5, highScore=5,
//    isGameComplete=0.
//  - After score 5, badColl=1 for 1 cycle -> isGameComplete=1, currScore=5;
//    further goodColl pulses leave currScore=5.
//  - goodColl rise and badColl=1 in the same cycle at score 3 -> currScore=3,
//    isGameComplete=1.
//  - MAX_SCORE=4 with 4 pulses -> currScore=4 and isGameComplete=1 on the 4th
//    update; a 5th pulse leaves currScore=4. With SCORE_TRACKER_RESTART_EN
//    defined, the 5th pulse gives currScore=0, highScore=4, isGameComplete=0.

Source files
------------

// File: rtl/score_tracker.sv
// Snake game score keeper: counts apples, tracks the high score, flags game over.
// Optional SCORE_TRACKER_RESTART_EN: a fresh apple after game over starts a new game.
module score_tracker #(
    parameter logic [6:0] MAX_SCORE = 7'd99
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       goodColl,
    input  logic       badColl,
    output logic [6:0] currScore,
    output logic [6:0] highScore,
    output logic       isGameComplete
);

    logic [6:0] curr_score_q, curr_score_d;
    logic [6:0] high_score_q, high_score_d;
    logic       done_q, done_d;
    logic       good_prev_q, good_prev_d;
    logic       good_edge;

    always_comb begin
        curr_score_d = curr_score_q;
        done_d       = done_q;
        good_prev_d  = goodColl;
        good_edge    = goodColl & ~good_prev_q;

        if (!done_q) begin
            if (badColl) begin
                done_d = 1'b1;
            end else if (good_edge && (curr_score_q < MAX_SCORE)) begin
                curr_score_d = curr_score_q + 7'd1;
                // compare before add so the win check never needs an 8th bit
                if (curr_score_q == MAX_SCORE - 7'd1) begin
                    done_d = 1'b1;
                end
            end
        end
`ifdef SCORE_TRACKER_RESTART_EN
        else if (good_edge && !badColl) begin
            curr_score_d = 7'd0;
            done_d       = 1'b0;
        end
`endif

        high_score_d = (curr_score_d > high_score_q) ? curr_score_d : high_score_q;
    end

    always_ff @(posedge clk) begin
        if (nRst) begin
            curr_score_q <= 7'd0;
            high_score_q <= 7'd0;
            done_q       <= 1'b0;
            good_prev_q  <= 1'b0;
        end else begin
            curr_score_q <= curr_score_d;
            high_score_q <= high_score_d;
            done_q       <= done_d;
            good_prev_q  <= good_prev_d;
        end
    end

    assign currScore      = curr_score_q;
    assign highScore      = high_score_q;
    assign isGameComplete = done_q;

endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker: directed spec scenarios plus random play on two
// instances (default MAX_SCORE and MAX_SCORE=4) against a game-rules model.
module tb_score_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       g0, b0, g1, b1;
    logic [6:0] cs0, hs0, cs1, hs1;
    logic       dn0, dn1;

    int checks   = 0;
    int failures = 0;

    int m_score [2];
    int m_high  [2];
    int m_done  [2];
    int m_prev  [2];
    int m_max   [2];

    always #5 clk = ~clk;

    score_tracker u_big (
        .clk(clk), .nRst(rst), .goodColl(g0), .badColl(b0),
        .currScore(cs0), .highScore(hs0), .isGameComplete(dn0)
    );

    score_tracker #(.MAX_SCORE(7'd4)) u_small (
        .clk(clk), .nRst(rst), .goodColl(g1), .badColl(b1),
        .currScore(cs1), .highScore(hs1), .isGameComplete(dn1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Game rules applied to one player's state for one clock edge.
    task automatic model(input int i, input bit r, input bit g, input bit b);
        bit apple;
        apple = g && (m_prev[i] == 0);
        if (r) begin
            m_score[i] = 0;
            m_high[i]  = 0;
            m_done[i]  = 0;
            m_prev[i]  = 0;
        end else begin
            if (m_done[i] == 0) begin
                if (b) begin
                    m_done[i] = 1;
                end else if (apple) begin
                    m_score[i]++;
                    if (m_score[i] == m_max[i]) m_done[i] = 1;
                end
            end else begin
`ifdef SCORE_TRACKER_RESTART_EN
                if (apple && !b) begin
                    m_score[i] = 0;
                    m_done[i]  = 0;
                end
`endif
            end
            if (m_score[i] > m_high[i]) m_high[i] = m_score[i];
            m_prev[i] = g;
        end
    endtask

    task automatic step(input bit r, input bit ga, input bit ba,
                        input bit gb, input bit bb);
        rst = r; g0 = ga; b0 = ba; g1 = gb; b1 = bb;
        @(posedge clk);
        model(0, r, ga, ba);
        model(1, r, gb, bb);
        #1;
        chk("big.curr", int'(cs0), m_score[0]);
        chk("big.high", int'(hs0), m_high[0]);
        chk("big.done", int'(dn0), m_done[0]);
        chk("small.curr", int'(cs1), m_score[1]);
        chk("small.high", int'(hs1), m_high[1]);
        chk("small.done", int'(dn1), m_done[1]);
    endtask

    task automatic pulse0();
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    task automatic pulse1();
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        m_max[0] = 99;
        m_max[1] = 4;
        for (int i = 0; i < 2; i++) begin
            m_score[i] = 0; m_high[i] = 0; m_done[i] = 0; m_prev[i] = 0;
        end
        rst = 1'b1; g0 = 0; b0 = 0; g1 = 0; b1 = 0;
        #2;

        // reset two cycles, then held one more
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst.curr", int'(cs0), 0);
        chk("rst.high", int'(hs0), 0);
        chk("rst.done", int'(dn0), 0);
        step(1, 1, 0, 1, 0);
        chk("rst.hold", int'(cs0), 0);

        // single apple with goodColl held high
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("apple.curr", int'(cs0), 1);
        chk("apple.high", int'(hs0), 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("apple.hold", int'(cs0), 1);
        step(0, 0, 0, 0, 0);

        // five pulses from a fresh game
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) pulse0();
        chk("five.curr", int'(cs0), 5);
        chk("five.high", int'(hs0), 5);
        chk("five.done", int'(dn0), 0);

        // loss, then apples ignored (or restart)
        step(0, 0, 1, 0, 0);
        chk("loss.done", int'(dn0), 1);
        chk("loss.curr", int'(cs0), 5);
        step(0, 0, 0, 0, 0);
        pulse0();
`ifdef SCORE_TRACKER_RESTART_EN
        chk("after.curr", int'(cs0), 0);
        chk("after.high", int'(hs0), 5);
`else
        chk("after.curr", int'(cs0), 5);
        chk("after.done", int'(dn0), 1);
`endif

        // simultaneous apple and bad collision at score 3
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) pulse0();
        step(0, 1, 1, 0, 0);
        chk("both.curr", int'(cs0), 3);
        chk("both.done", int'(dn0), 1);
        step(0, 0, 0, 0, 0);

        // win at MAX_SCORE=4
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) pulse1();
        chk("win3.done", int'(dn1), 0);
        step(0, 0, 0, 1, 0);
        chk("win.curr", int'(cs1), 4);
        chk("win.done", int'(dn1), 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
`ifdef SCORE_TRACKER_RESTART_EN
        chk("win5.curr", int'(cs1), 0);
        chk("win5.high", int'(hs1), 4);
        chk("win5.done", int'(dn1), 0);
`else
        chk("win5.curr", int'(cs1), 4);
        chk("win5.done", int'(dn1), 1);
`endif
        step(0, 0, 0, 0, 0);

        // random play
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
